// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave: one transaction at a time, INCR bursts of 32-bit beats.
// Optional AXI_SRAM_RANGE_CHECK_EN: out-of-range beats are dropped or read as zero and answered with SLVERR.
module axi_sram_slave #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned DEPTH  = 32'(1) << DEPTH_LOG2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WA_W   = 30;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_DATA, WR_RESP} state_t;

  state_t              state;
  logic [WA_W-1:0]     raddr;
  logic [WA_W-1:0]     waddr;
  logic [7:0]          rlen;
  logic [7:0]          rcnt;
  logic                werr;

  logic [WA_W-1:0]     rd_word_c;
  logic                rd_oob_c;
  logic                wr_oob_c;
  logic [DATA_W-1:0]   mem_rdata_c;
  logic                mem_we_c;
  logic                unused_addr_bits_c;

  assign unused_addr_bits_c = ^{awaddr[1:0], araddr[1:0], awlen};

  // Handshake readiness decodes straight from the state; write wins over read in IDLE.
  assign awready = (state == IDLE);
  assign arready = (state == IDLE) && !awvalid;
  assign wready  = (state == WR_DATA);
  assign bvalid  = (state == WR_RESP);

  // Word fetched on this edge: first beat at the AR handshake, next beat during a burst.
  assign rd_word_c = (state == IDLE) ? araddr[31:2] : raddr + WA_W'(1);

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign rd_oob_c = (rd_word_c[WA_W-1:DEPTH_LOG2] != '0);
  assign wr_oob_c = (waddr[WA_W-1:DEPTH_LOG2] != '0);
`else
  assign rd_oob_c = 1'b0;
  assign wr_oob_c = 1'b0;
`endif

  assign mem_we_c = (state == WR_DATA) && wvalid && !wr_oob_c;

  // 2-state storage powers up as zero; 4-state storage powers up unknown.
  if (INIT_ZERO) begin : g_mem_zero
    bit [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we_c) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mem[waddr[DEPTH_LOG2-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    assign mem_rdata_c = mem[rd_word_c[DEPTH_LOG2-1:0]];
  end else begin : g_mem_x
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (mem_we_c) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb[b]) mem[waddr[DEPTH_LOG2-1:0]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    assign mem_rdata_c = mem[rd_word_c[DEPTH_LOG2-1:0]];
  end

  // Transaction FSM with registered R and B channel payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      raddr  <= '0;
      waddr  <= '0;
      rlen   <= '0;
      rcnt   <= '0;
      werr   <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      bid    <= '0;
      bresp  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (awvalid) begin
            bid   <= awid;
            waddr <= awaddr[31:2];
            werr  <= 1'b0;
            state <= WR_DATA;
          end else if (arvalid) begin
            rid    <= arid;
            raddr  <= araddr[31:2];
            rlen   <= arlen;
            rcnt   <= '0;
            rdata  <= rd_oob_c ? '0 : mem_rdata_c;
            rresp  <= rd_oob_c ? RESP_SLVERR : RESP_OKAY;
            rlast  <= (arlen == 8'd0);
            rvalid <= 1'b1;
            state  <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
              state  <= IDLE;
            end else begin
              raddr <= rd_word_c;
              rcnt  <= rcnt + 8'd1;
              rdata <= rd_oob_c ? '0 : mem_rdata_c;
              rresp <= rd_oob_c ? RESP_SLVERR : RESP_OKAY;
              rlast <= ((rcnt + 8'd1) == rlen);
            end
          end
        end
        WR_DATA: begin
          if (wvalid) begin
            waddr <= waddr + WA_W'(1);
            if (wr_oob_c) werr <= 1'b1;
            if (wlast) begin
              bresp <= (werr || wr_oob_c) ? RESP_SLVERR : RESP_OKAY;
              state <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: word-level memory model plus an expected-beat queue
// checked every cycle on the R channel, and literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int unsigned D     = 12;
  localparam int unsigned DEPTH = 1 << D;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_sram_slave #(.DEPTH_LOG2(D), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] mdl [DEPTH];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          cmp_en = 1'b0;
  bit          rr_toggle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    return a >= 32'(4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [D-1:0] widx(input logic [31:0] a);
    return a[D+1:2];
  endfunction

  // Burst write; the model memory is updated beat by beat as each beat is accepted.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int n,
                          input logic [31:0] d0, input logic [31:0] dinc, input logic [3:0] strb);
    logic        err;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
    err = 1'b0;
    awid = id; awaddr = addr; awlen = 8'(n - 1); awvalid = 1'b1;
    @(negedge clk);
    chk("awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(4 * i);
      d = d0 + 32'(i) * dinc;
      wdata = d; wstrb = strb; wlast = (i == n - 1); wvalid = 1'b1;
      @(negedge clk);
      chk("wready", 32'(wready), 32'd1);
      if (oob(a)) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (strb[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // AR handshake, then queue the beats the model says must come back.
  task automatic issue_read(input logic [3:0] id, input logic [31:0] addr, input int n, output int waited);
    beat_t       e;
    logic [31:0] a;
    arid = id; araddr = addr; arlen = 8'(n - 1); arvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!arready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(4 * i);
      e.id = id;
      e.last = (i == n - 1);
      if (oob(a)) begin e.data = 32'h0; e.resp = 2'b10; end
      else begin e.data = mdl[widx(a)]; e.resp = 2'b00; end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_read_done(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("read_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // R channel check on every cycle: idle when nothing is owed, else the head beat, held until accepted.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        if (rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL r_idle: rvalid=%b, expected 0", rvalid);
        end
      end else begin
        if (rvalid !== 1'b1 || rdata !== exp_q[0].data || rid !== exp_q[0].id ||
            rlast !== exp_q[0].last || rresp !== exp_q[0].resp) begin
          n_fail++;
          $display("FAIL r_beat: got v=%b d=%h id=%h last=%b resp=%b, expected v=1 d=%h id=%h last=%b resp=%b",
                   rvalid, rdata, rid, rlast, rresp, exp_q[0].data, exp_q[0].id, exp_q[0].last, exp_q[0].resp);
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
          got_q.push_back(rdata);
          exp_q.delete(0);
        end
      end
    end
  end

  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rready = rr_toggle ? ~rready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] exp_word;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
    rst = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rlast",   32'(rlast),   32'd0);
    chk("rst_bid",     32'(bid),     32'd0);
    chk("rst_rid",     32'(rid),     32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // Four-beat write then back-to-back read of the same burst.
    do_write(4'h3, 32'h10, 4, 32'hA0, 32'h1, 4'hF);
    chk("model_0x1c", mdl[7], 32'hA3);
    got_q.delete();
    issue_read(4'h3, 32'h10, 4, w);
    wait_read_done(20);
    chk("burst_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++) chk("burst_data", got_q[i], 32'hA0 + 32'(i));

    // Byte strobes, including an all-zero strobe that must not write.
    do_write(4'h1, 32'h20, 1, 32'h11223344, 32'h0, 4'hF);
    do_write(4'h1, 32'h20, 1, 32'hFFFFFFFF, 32'h0, 4'b0101);
    do_write(4'h2, 32'h20, 1, 32'hDEADBEEF, 32'h0, 4'h0);
    chk("model_0x20", mdl[8], 32'h11FF33FF);
    got_q.delete();
    issue_read(4'h1, 32'h20, 1, w);
    wait_read_done(20);
    chk("strobe_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("strobe_data", got_q[0], 32'h11FF33FF);

    // Eight-beat read with rready toggling.
    do_write(4'h4, 32'h100, 8, 32'h0B000000, 32'h11, 4'hF);
    rr_toggle = 1'b1;
    got_q.delete();
    issue_read(4'h4, 32'h100, 8, w);
    wait_read_done(80);
    rr_toggle = 1'b0;
    chk("toggle_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("toggle_last", got_q[7], 32'h0B000077);

    // Simultaneous AW and AR: write first, read held off until the B handshake.
    @(posedge clk); #1;
    awid = 4'h5; awaddr = 32'h40; awlen = 8'd0; awvalid = 1'b1;
    arid = 4'h6; araddr = 32'h40; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    chk("both_awready", 32'(awready), 32'd1);
    chk("both_arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("both_wready", 32'(wready), 32'd1);
    chk("both_arready_w", 32'(arready), 32'd0);
    mdl[widx(32'h40)] = 32'hCAFEF00D;
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bstall_bvalid", 32'(bvalid), 32'd1);
      chk("bstall_arready", 32'(arready), 32'd0);
      chk("bstall_bid", 32'(bid), 32'h5);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    chk("bhs_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
    got_q.delete();
    issue_read(4'h6, 32'h40, 1, w);
    chk("ar_after_b_wait", 32'(w), 32'd0);
    wait_read_done(20);
    if (got_q.size() > 0) chk("ar_after_b_data", got_q[0], 32'hCAFEF00D);

    // Reset during beat 2 of a 4-beat read; memory must survive.
    do_write(4'h7, 32'h200, 4, 32'h51000000, 32'h1, 4'hF);
    issue_read(4'h7, 32'h200, 4, w);
    w = 0;
    while (exp_q.size() > 3 && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rlast", 32'(rlast), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_arready", 32'(arready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete();
    issue_read(4'h7, 32'h200, 4, w);
    chk("ar_after_rst_wait", 32'(w), 32'd0);
    wait_read_done(20);
    if (got_q.size() == 4) chk("after_rst_data", got_q[3], 32'h51000003);

    // Read past the top of memory.
    do_write(4'h8, 32'h0, 1, 32'h5A5A0001, 32'h0, 4'hF);
    got_q.delete();
    issue_read(4'h9, 32'h4000, 1, w);
    wait_read_done(20);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    exp_word = 32'h0;
`else
    exp_word = 32'h5A5A0001;
`endif
    if (got_q.size() > 0) chk("oob_read", got_q[0], exp_word);

    // Burst crossing the top of memory.
    do_write(4'hA, 32'h3FFC, 2, 32'h77000000, 32'h1, 4'hF);
    got_q.delete();
    issue_read(4'hA, 32'h3FFC, 2, w);
    wait_read_done(20);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    exp_word = 32'h0;
`else
    exp_word = 32'h77000001;
`endif
    if (got_q.size() == 2) chk("wrap_beat2", got_q[1], exp_word);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter DEPTH_LOG2, default 12: memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1: 1 zero-fills memory at time 0; 0 leaves it uninitialised.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 awid  input  4  write ID.
REQ-006 awaddr  input  32  write byte address; bits [1:0] ignored.
REQ-007 awlen  input  8  write beats minus 1.
REQ-008 awvalid  input  1  write address valid.
REQ-009 awready  output  1  write address ready.
REQ-010 wdata  input  32  write data.
REQ-011 wstrb  input  4  byte enables.
REQ-012 wlast  input  1  last write beat.
REQ-013 wvalid  input  1  write data valid.
REQ-014 wready  output  1  write data ready.
REQ-015 bid  output  4  echoed awid.
REQ-016 bresp  output  2  write response.
REQ-017 bvalid  output  1  write response valid.
REQ-018 bready  input  1  write response ready.
REQ-019 arid  input  4  read ID.
REQ-020 araddr  input  32  read byte address; bits [1:0] ignored.
REQ-021 arlen  input  8  read beats minus 1.
REQ-022 arvalid  input  1  read address valid.
REQ-023 arready  output  1  read address ready.
REQ-024 rid  output  4  echoed arid.
REQ-025 rdata  output  32  read data.
REQ-026 rresp  output  2  read response.
REQ-027 rlast  output  1  last read beat.
REQ-028 rvalid  output  1  read data valid.
REQ-029 rready  input  1  read data ready.

Function
REQ-030 One transaction at a time; FSM states IDLE, RD_BURST, WR_DATA, WR_RESP; all bursts are INCR with 4-byte beats.
REQ-031 In IDLE, awready=1; arready=!awvalid. With both valid in the same cycle, the write is accepted and the read waits.
REQ-032 AR handshake latches arid, word address and arlen, then enters RD_BURST; rvalid rises exactly 1 cycle after the handshake.
REQ-033 In RD_BURST, on rvalid&&rready the beat counter and address each increment by one; the next beat is valid on the following cycle with no bubble.
REQ-034 rdata, rid, rlast and rresp stay stable while rvalid&&!rready.
REQ-035 rlast=1 only on beat arlen+1; its handshake returns the FSM to IDLE.
REQ-036 AW handshake latches awid and word address, then enters WR_DATA, where wready=1.
REQ-037 Each wvalid&&wready writes the bytes selected by wstrb (wstrb=0 writes nothing) and increments the address.
REQ-038 The write burst ends on the wlast handshake regardless of awlen; the FSM then enters WR_RESP with bvalid=1 and bid set to the latched awid.
REQ-039 bvalid holds until bready; that handshake returns the FSM to IDLE.
REQ-040 Word address arithmetic is DEPTH_LOG2 bits wide and wraps modulo memory size, except when REQ-046 applies.
REQ-041 Without REQ-046, bresp and rresp are always 2'b00 (OKAY).

Reset
REQ-042 rst asserted at any time, including mid-burst, forces IDLE asynchronously: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, rdata=0, bresp=0, rresp=0.
REQ-043 A partially completed write keeps the beats already written; no response is ever issued for the aborted transaction.
REQ-044 Reset never modifies memory contents.

Configuration
REQ-045 The macro AXI_SRAM_RANGE_CHECK_EN controls address range checking.
REQ-046 With AXI_SRAM_RANGE_CHECK_EN defined: any beat whose byte address is >= 4*2^DEPTH_LOG2 is not written, reads return 0, rresp=2'b10 on that beat, and bresp=2'b10 if any beat of the write burst was out of range. Without the macro: addresses wrap, responses are always OKAY.

Verification
REQ-047 Write awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF, then read the same burst with rready=1 -> rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, rlast on the 4th beat, bid=rid=ID, resp=0.
REQ-048 Write 0x11223344 to 0x20, then write 0xFFFFFFFF to 0x20 with wstrb=4'b0101, then read 0x20 -> 0x11FF33FF.
REQ-049 Read awlen-style burst arlen=7 with rready toggling 1,0,1,0 -> each beat is held stable while rready=0, 8 beats total, no beat lost or duplicated.
REQ-050 awvalid and arvalid asserted in the same cycle -> AW accepted first; AR accepted only after the B handshake; bready held 0 for 5 cycles keeps bvalid=1 and arready=0 throughout.
REQ-051 Assert rst during beat 2 of a 4-beat read -> rvalid=0 in the same cycle; the next AR is accepted one cycle after rst deasserts.
REQ-052 With AXI_SRAM_RANGE_CHECK_EN, DEPTH_LOG2=12: read 0x4000 -> rresp=2'b10, rdata=0; without the macro, the same read returns the word at 0x0.
